// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the core MEM stage (C)
// and the UART debug/loader master (D). One access at a time; loads wait
// MEM_LAT cycles in READ_WAIT and return data with a one-cycle rvalid pulse.
module dmem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LAT        = 1,
  parameter int MAX_CORE_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // core master
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [2:0]        c_fn3,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              core_stall,
  // debug master
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_fn3,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_fn3,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int BURST_W = $clog2(MAX_CORE_BURST + 1);

  typedef enum logic {IDLE, READ_WAIT} state_t;

  state_t              r_state;
  logic [LAT_W-1:0]    r_wait;
  logic [BURST_W-1:0]  r_burst;
  logic                r_owner_d;
  logic [DATA_W-1:0]   r_c_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic w_idle;
  logic w_rdone;
  logic w_burst_ok;
  logic w_c_win;
  logic w_d_win;

  // Decisions are gated with rst_n so every output reads 0 while reset is held,
  // even if a master keeps its request asserted.
  assign w_idle     = rst_n & (r_state == IDLE);
  assign w_rdone    = rst_n & (r_state == READ_WAIT) & (r_wait == '0);
  assign w_burst_ok = (r_burst < BURST_W'(MAX_CORE_BURST));
  assign w_c_win    = w_idle & c_req & (~d_req | w_burst_ok);
  assign w_d_win    = w_idle & d_req & ~w_c_win;

  assign c_gnt    = w_c_win;
  assign d_gnt    = w_d_win;
  assign c_rvalid = w_rdone & ~r_owner_d;
  assign d_rvalid = w_rdone & r_owner_d;

  // Read data is forwarded in the rvalid cycle and held from the register afterwards.
  assign c_rdata = c_rvalid ? mem_rdata : r_c_rdata;
  assign d_rdata = d_rvalid ? mem_rdata : r_d_rdata;

  assign core_stall = rst_n & ~c_rvalid &
                      ((c_req & ~w_c_win) | ((r_state == READ_WAIT) & ~r_owner_d));

  // Memory port mux: driven from the winner in the grant cycle, zero otherwise.
  always_comb begin
    mem_en    = w_c_win | w_d_win;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_fn3   = '0;
    if (w_c_win) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_fn3   = c_fn3;
    end else if (w_d_win) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_fn3   = d_fn3;
    end
  end

  // Access sequencer: loads park in READ_WAIT until memory data is due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_owner_d <= 1'b0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_en && !mem_we) begin
            r_state   <= READ_WAIT;
            r_wait    <= LAT_W'(MEM_LAT - 1);
            r_owner_d <= w_d_win;
          end
        end
        READ_WAIT: begin
          if (r_wait == '0) begin
            r_state <= IDLE;
            if (r_owner_d) r_d_rdata <= mem_rdata;
            else           r_c_rdata <= mem_rdata;
          end else begin
            r_wait <= r_wait - LAT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Fairness counter: contested C grants count up, any D grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= '0;
    end else if (w_d_win) begin
      r_burst <= '0;
    end else if (w_c_win && d_req) begin
      r_burst <= r_burst + BURST_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: randomized two-master traffic against a cycle-level
// reference model; expected grants, read returns and stall are queued by the
// driver and consumed by an independent monitor.
module tb_dmem_arbiter;

  localparam int LAT  = 2;
  localparam int MAXB = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [2:0]  c_fn3, d_fn3;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, core_stall;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_fn3;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_CORE_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_fn3(c_fn3),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_fn3(d_fn3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_fn3(mem_fn3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {bit act; bit we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] fn3;} req_t;
  typedef struct {int cyc; bit who; bit we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] fn3;} gexp_t;
  typedef struct {int cyc; bit who; logic [31:0] data;} rexp_t;
  typedef struct {int cyc; bit v;} sexp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  req_t  rc, rd;
  gexp_t gq[$];
  rexp_t rq[$];
  sexp_t sq[$];

  // reference model state
  int          free_cyc = 0;
  int          streak = 0;
  int          c_ld = -1;
  int          c_rv = -1;
  logic [31:0] model_mem[16];
  logic [31:0] last_c = '0;
  logic [31:0] last_d = '0;

  function automatic logic [31:0] seed(int i);
    return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // behavioural memory attached to the DUT memory port
  logic [31:0] tb_mem[16];
  bit          tb_wr[16];
  logic [31:0] pipe[LAT];
  assign mem_rdata = pipe[0];

  always @(posedge clk) begin
    for (int i = 0; i < LAT - 1; i++) pipe[i] <= pipe[i + 1];
    pipe[LAT-1] <= 32'hDEAD_0BAD;
    if (mem_en) begin
      if (mem_we) begin
        tb_mem[int'(mem_addr[5:2])] <= mem_wdata;
        tb_wr[int'(mem_addr[5:2])]  <= 1'b1;
      end else begin
        pipe[LAT-1] <= tb_wr[int'(mem_addr[5:2])] ? tb_mem[int'(mem_addr[5:2])]
                                                  : seed(int'(mem_addr[5:2]));
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic req_t new_req(int pwe);
    req_t r;
    r.act   = 1'b1;
    r.we    = ($urandom_range(0, 99) < pwe);
    r.addr  = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
    r.wdata = $urandom;
    r.fn3   = 3'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic drive_inputs();
    c_req = rc.act; c_we = rc.we; c_addr = rc.addr; c_wdata = rc.wdata; c_fn3 = rc.fn3;
    d_req = rd.act; d_we = rd.we; d_addr = rd.addr; d_wdata = rd.wdata; d_fn3 = rd.fn3;
  endtask

  // random request generation: issue / withdraw probabilities in percent
  task automatic gen(int pc, int pd, int pwe, int pwd);
    if (rc.act && $urandom_range(0, 99) < pwd) rc.act = 1'b0;
    else if (!rc.act && $urandom_range(0, 99) < pc) rc = new_req(pwe);
    if (rd.act && $urandom_range(0, 99) < pwd) rd.act = 1'b0;
    else if (!rd.act && $urandom_range(0, 99) < pd) rd = new_req(pwe);
  endtask

  // one clock cycle: drive, then predict from the arbitration rules
  task automatic step();
    bit    gc, gd;
    req_t  w;
    gexp_t g;
    rexp_t r;
    sexp_t s;
    @(negedge clk);
    cyc++;
    drive_inputs();
    if (rst_n !== 1'b1) return;
    gc = 1'b0;
    gd = 1'b0;
    if (cyc >= free_cyc) begin
      if (rc.act && rd.act) begin
        if (streak < MAXB) begin gc = 1'b1; streak++; end
        else begin gd = 1'b1; streak = 0; end
      end else if (rc.act) begin
        gc = 1'b1;
      end else if (rd.act) begin
        gd = 1'b1;
        streak = 0;
      end
    end
    s.cyc = cyc;
    s.v   = (cyc != c_rv) && ((rc.act && !gc) || (c_ld < cyc && cyc < c_rv));
    sq.push_back(s);
    if (gc || gd) begin
      w = gc ? rc : rd;
      g = '{cyc, gd, w.we, w.addr, w.wdata, w.fn3};
      gq.push_back(g);
      if (w.we) begin
        model_mem[w.addr[5:2]] = w.wdata;
        free_cyc = cyc + 1;
      end else begin
        r = '{cyc + LAT, gd, model_mem[w.addr[5:2]]};
        rq.push_back(r);
        free_cyc = cyc + LAT + 1;
        if (gc) begin c_ld = cyc; c_rv = cyc + LAT; end
      end
      if (gc) rc.act = 1'b0;
      else    rd.act = 1'b0;
    end
  endtask

  task automatic model_reset();
    gq.delete(); rq.delete(); sq.delete();
    free_cyc = 0; streak = 0; c_ld = -1; c_rv = -1;
    last_c = '0; last_d = '0;
  endtask

  // monitor: consumes expectations every cycle, away from the clock edge
  initial begin
    gexp_t g;
    rexp_t r;
    sexp_t s;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) continue;
      if (sq.size() != 0 && sq[0].cyc == cyc) begin
        s = sq.pop_front();
        chk("core_stall", 128'(core_stall), 128'(s.v));
      end
      if (gq.size() != 0 && gq[0].cyc == cyc) begin
        g = gq.pop_front();
        chk("grant", 128'({c_gnt, d_gnt, mem_en, mem_we, mem_fn3, mem_addr, mem_wdata}),
                     128'({!g.who, g.who, 1'b1, g.we, g.fn3, g.addr, g.wdata}));
      end else begin
        chk("no_grant", 128'({c_gnt, d_gnt, mem_en}), 128'(0));
      end
      if (rq.size() != 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        if (r.who) begin
          chk("d_rvalid", 128'({c_rvalid, d_rvalid, d_rdata}), 128'({1'b0, 1'b1, r.data}));
          last_d = r.data;
          chk("c_rdata_hold", 128'(c_rdata), 128'(last_c));
        end else begin
          chk("c_rvalid", 128'({c_rvalid, d_rvalid, c_rdata}), 128'({1'b1, 1'b0, r.data}));
          last_c = r.data;
          chk("d_rdata_hold", 128'(d_rdata), 128'(last_d));
        end
      end else begin
        chk("no_rvalid", 128'({c_rvalid, d_rvalid}), 128'(0));
        chk("c_rdata_hold", 128'(c_rdata), 128'(last_c));
        chk("d_rdata_hold", 128'(d_rdata), 128'(last_d));
      end
    end
  end

  task automatic check_reset_outputs();
    chk("reset_ctrl", 128'({c_gnt, c_rvalid, d_gnt, d_rvalid, core_stall, mem_en, mem_we}), 128'(0));
    chk("reset_bus", 128'({mem_addr, mem_wdata, mem_fn3}), 128'(0));
    chk("reset_rdata", 128'({c_rdata, d_rdata}), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = seed(i);
      tb_wr[i]     = 1'b0;
    end
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    rst_n = 1'b0;
    rc = new_req(50);
    rd = new_req(50);
    drive_inputs();
    #7;
    check_reset_outputs();
    rc.act = 1'b0;
    rd.act = 1'b0;
    drive_inputs();
    @(negedge clk);
    #3 rst_n = 1'b1;

    // single store, then store+load of a known word at 0x20
    rc = '{1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2};
    step();
    rc = '{1'b1, 1'b1, 32'h20, 32'h1234_5678, 3'd2};
    step();
    rc = '{1'b1, 1'b0, 32'h20, 32'h0, 3'd2};
    step();
    repeat (4) step();

    // mixed random traffic with occasional withdrawals
    repeat (300) begin gen(40, 30, 50, 5); step(); end

    // continuous contention, stores only
    rc.act = 1'b0; rd.act = 1'b0;
    repeat (4) step();
    repeat (24) begin gen(100, 100, 100, 0); step(); end

    // debug-only back-to-back stores
    rc.act = 1'b0;
    repeat (8) begin gen(0, 100, 100, 0); step(); end

    // reset while a debug load is outstanding
    rc.act = 1'b0; rd.act = 1'b0;
    repeat (4) step();
    rd = new_req(0);
    step();
    step();
    #3;
    rc = new_req(100);
    drive_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    step();
    step();
    #3 rst_n = 1'b1;
    repeat (6) step();

    // random tail with frequent withdrawals
    repeat (120) begin gen(30, 30, 30, 20); step(); end

    rc.act = 1'b0; rd.act = 1'b0;
    repeat (6) step();
    #3;
    chk("grants_drained", 128'(gq.size()), 128'(0));
    chk("reads_drained", 128'(rq.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
